// File: rtl/scrypt_pkg.sv
// Shared definitions for the scrypt ROMix scratchpad: default geometry and FSM state encodings.
package scrypt_pkg;

  localparam int SCRYPT_ADDR_W = 10;
  localparam int SCRYPT_DATA_W = 512;
  localparam int SCRYPT_N      = 2 ** SCRYPT_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/scratchpad_seq_pad_ram.sv
// pad_ram: simple dual-port scratchpad, synchronous write and registered synchronous read.
// No reset on the array or read register so it maps onto block RAM.
module pad_ram
  import scrypt_pkg::*;
#(
  parameter int ADDR_W = SCRYPT_ADDR_W,
  parameter int DATA_W = SCRYPT_DATA_W
) (
  input  logic              clk,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_rdEn,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdData;

  always_ff @(posedge clk) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
    if (i_rdEn) r_rdData <= r_mem[i_rdAddr];
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/scratchpad_seq.sv
// ROMix scratchpad sequencer: fills V[0..N-1] from the salsa pipeline, then serves N reads V[j].
// Optional macro SCRATCH_RDREG_EN adds an output register after the RAM (read latency 2 instead of 1).
module scratchpad_seq
  import scrypt_pkg::*;
#(
  parameter int ADDR_W = SCRYPT_ADDR_W,
  parameter int DATA_W = SCRYPT_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              step_valid,
  input  logic [DATA_W-1:0] X0,
  input  logic [ADDR_W-1:0] Xaddr,
  output logic [DATA_W-1:0] Bx,
  output logic              Bx_valid,
  output logic [1:0]        phase,
  output logic              busy,
  output logic              done
);

  localparam int N = 2 ** ADDR_W;

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_done;
  logic              w_wrEn;
  logic              w_rdEn;
  logic              w_cntLast;
  logic              w_lastOut;
  logic [DATA_W-1:0] w_ramQ;

  assign w_wrEn    = (r_state == ST_WRITE) && step_valid;
  assign w_rdEn    = (r_state == ST_READ) && step_valid;
  assign w_cntLast = (r_cnt == ADDR_W'(N - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  // DONE is held until the done pulse has been emitted, then the FSM returns to IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_nextState = ST_WRITE;
      ST_WRITE: if (w_wrEn && w_cntLast) w_nextState = ST_READ;
      ST_READ:  if (w_rdEn && w_cntLast) w_nextState = ST_DONE;
      ST_DONE:  if (r_done) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_cnt <= '0;
    else if (r_state == ST_IDLE && start)  r_cnt <= '0;
    else if (w_wrEn || w_rdEn)             r_cnt <= r_cnt + 1'b1;
  end

  pad_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_pad_ram (
    .clk      (clk),
    .i_wrEn   (w_wrEn),
    .i_wrAddr (r_cnt),
    .i_wrData (X0),
    .i_rdEn   (w_rdEn),
    .i_rdAddr (Xaddr),
    .o_rdData (w_ramQ)
  );

  // Valid and last-read tags travel alongside the RAM data so done lands one cycle after the final Bx.
`ifdef SCRATCH_RDREG_EN
  logic [1:0]        r_vldPipe;
  logic [1:0]        r_lastPipe;
  logic [DATA_W-1:0] r_bx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vldPipe  <= '0;
      r_lastPipe <= '0;
      r_bx       <= '0;
    end else begin
      r_vldPipe  <= {r_vldPipe[0], w_rdEn};
      r_lastPipe <= {r_lastPipe[0], w_rdEn && w_cntLast};
      r_bx       <= r_vldPipe[0] ? w_ramQ : '0;
    end
  end

  assign Bx        = r_bx;
  assign Bx_valid  = r_vldPipe[1];
  assign w_lastOut = r_lastPipe[1];
`else
  logic r_vld;
  logic r_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld  <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_vld  <= w_rdEn;
      r_last <= w_rdEn && w_cntLast;
    end
  end

  // RAM read register has no reset, so gate the data to keep Bx at zero when not valid.
  assign Bx        = r_vld ? w_ramQ : '0;
  assign Bx_valid  = r_vld;
  assign w_lastOut = r_last;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_done <= 1'b0;
    else          r_done <= w_lastOut;
  end

  assign done  = r_done;
  assign phase = r_state;
  assign busy  = (r_state == ST_WRITE) || (r_state == ST_READ);

endmodule

// File: tb/tb_scratchpad_seq.sv
// Self-checking bench for scratchpad_seq: a behavioural array/queue model predicts Bx data, latency and done timing.
// Define SCRATCH_RDREG_EN here and in the RTL together to check the two-cycle latency build.
module tb_scratchpad_seq;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 512;
  localparam int N      = 1 << ADDR_W;
`ifdef SCRATCH_RDREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              step_valid = 1'b0;
  logic [DATA_W-1:0] X0 = '0;
  logic [ADDR_W-1:0] Xaddr = '0;
  logic [DATA_W-1:0] Bx;
  logic              Bx_valid;
  logic [1:0]        phase;
  logic              busy;
  logic              done;

  scratchpad_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .step_valid (step_valid),
    .X0         (X0),
    .Xaddr      (Xaddr),
    .Bx         (Bx),
    .Bx_valid   (Bx_valid),
    .phase      (phase),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  int                vectors = 0;
  int                miscompares = 0;
  int                cyc = 0;
  exp_t              expQ[$];
  exp_t              monE;
  logic [DATA_W-1:0] model [N];
  int                mState = 0;
  int                mCnt = 0;
  int                expDone = -1;

  always @(posedge clk) cyc++;

  // Model phases: 0 idle, 1 filling, 2 reading, 3 waiting for done.
  always @(negedge clk) begin
    if (reset_n) begin
      if (Bx_valid) begin
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL bx_unexpected cyc=%0d got Bx_valid=1 expected 0", cyc);
        end else begin
          monE = expQ.pop_front();
          if (Bx !== monE.data || cyc != monE.due) begin
            miscompares++;
            $display("[TB] FAIL bx_data cyc=%0d due=%0d got=%h exp=%h", cyc, monE.due, Bx, monE.data);
          end
        end
      end else if (expQ.size() > 0 && expQ[0].due <= cyc) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL bx_missing cyc=%0d got Bx_valid=0 expected 1 (due %0d)", cyc, expQ[0].due);
        monE = expQ.pop_front();
      end
      if (done || cyc == expDone) begin
        vectors++;
        if (done !== (cyc == expDone)) begin
          miscompares++;
          $display("[TB] FAIL done_timing cyc=%0d got done=%b expected done at cyc %0d", cyc, done, expDone);
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] pattern(input int k);
    return {16{k}};
  endfunction

  function automatic logic [DATA_W-1:0] randBlk();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] randAddr();
    return ADDR_W'($urandom_range(0, N - 1));
  endfunction

  task automatic drive(input logic st, input logic v, input logic [DATA_W-1:0] x,
                       input logic [ADDR_W-1:0] a);
    int   accept;
    exp_t ne;
    @(posedge clk);
    #1;
    start      = st;
    step_valid = v;
    X0         = x;
    Xaddr      = a;
    accept     = cyc + 1;
    if (st && mState == 0) begin
      mState = 1;
      mCnt   = 0;
    end else if (v && mState == 1) begin
      model[mCnt] = x;
      mCnt++;
      if (mCnt == N) begin
        mState = 2;
        mCnt   = 0;
      end
    end else if (v && mState == 2) begin
      ne.data = model[a];
      ne.due  = accept + LAT - 1;
      expQ.push_back(ne);
      mCnt++;
      if (mCnt == N) begin
        mState  = 3;
        expDone = accept + LAT;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, randBlk(), randAddr());
  endtask

  task automatic wait_done(input string name);
    int lim;
    lim = 0;
    drive(1'b0, 1'b0, '0, '0);
    while (cyc < expDone + 1 && lim < 8 * N) begin
      @(posedge clk);
      #1;
      lim++;
    end
    vectors++;
    if (lim >= 8 * N) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout got cyc=%0d expected done by cyc %0d", name, cyc, expDone);
    end
    vectors++;
    if (phase !== 2'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_idle_after_done got phase=%0d busy=%b expected 0/0", name, phase, busy);
    end
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_pending_reads got %0d outstanding expected 0", name, expQ.size());
    end
    mState  = 0;
    expDone = -1;
    expQ.delete();
  endtask

  task automatic fill_random(input int maxGap);
    drive(1'b1, 1'b0, '0, '0);
    for (int k = 0; k < N; k++) begin
      drive(1'b0, 1'b1, randBlk(), randAddr());
      if (maxGap > 0) idle($urandom_range(0, maxGap));
    end
    drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    vectors++;
    if (Bx !== '0 || Bx_valid !== 1'b0 || phase !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got Bx_valid=%b phase=%0d busy=%b done=%b Bx!=0:%b expected all 0",
               Bx_valid, phase, busy, done, (Bx !== '0));
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_ignore_idle();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, randBlk(), randAddr());
      vectors++;
      if (phase !== 2'd0 || busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle_step_ignored got phase=%0d busy=%b expected 0/0", phase, busy);
      end
    end
  endtask

  task automatic test_fill();
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b0, 1'b0, '0, '0);
    vectors++;
    if (phase !== 2'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fill_enter_write got phase=%0d busy=%b expected 1/1", phase, busy);
    end
    for (int k = 0; k < N; k++) begin
      drive(k == 500, 1'b1, pattern(k), randAddr());
      idle($urandom_range(0, 2));
      if (k == N - 2) begin
        vectors++;
        if (phase !== 2'd1) begin
          miscompares++;
          $display("[TB] FAIL fill_still_write got phase=%0d expected 1", phase);
        end
      end
    end
    drive(1'b0, 1'b0, '0, '0);
    vectors++;
    if (phase !== 2'd2 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fill_enter_read got phase=%0d busy=%b expected 2/1", phase, busy);
    end
  endtask

  task automatic test_readback();
    logic [ADDR_W-1:0] addrs [3];
    addrs[0] = ADDR_W'(5);
    addrs[1] = ADDR_W'(1023);
    addrs[2] = ADDR_W'(0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, randBlk(), addrs[i]);
      idle(3);
    end
    for (int i = 3; i < N; i++) drive(1'b0, 1'b1, randBlk(), randAddr());
    wait_done("readback");
  endtask

  task automatic test_back_to_back();
    fill_random(0);
    vectors++;
    if (phase !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL b2b_enter_read got phase=%0d expected 2", phase);
    end
    for (int i = 0; i < N; i++) drive(1'b0, 1'b1, randBlk(), ADDR_W'(N - 1 - i));
    wait_done("stream");
  endtask

  task automatic test_reset_mid();
    fill_random(1);
    for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, randBlk(), randAddr());
    @(posedge clk);
    #1;
    reset_n    = 1'b0;
    step_valid = 1'b0;
    start      = 1'b0;
    expQ.delete();
    expDone = -1;
    mState  = 0;
    #1;
    vectors++;
    if (Bx !== '0 || Bx_valid !== 1'b0 || phase !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs got Bx_valid=%b phase=%0d busy=%b done=%b Bx!=0:%b expected all 0",
               Bx_valid, phase, busy, done, (Bx !== '0));
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(4);
    vectors++;
    if (phase !== 2'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_stays_idle got phase=%0d busy=%b expected 0/0", phase, busy);
    end
  endtask

  task automatic test_full_pass();
    fill_random(2);
    for (int i = 0; i < N; i++) begin
      drive(1'b0, 1'b1, randBlk(), randAddr());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    wait_done("fullpass");
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got no finish expected completion within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_ignore_idle();
    test_fill();
    test_readback();
    test_back_to_back();
    test_reset_mid();
    test_full_pass();
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scratchpad_seq.md
SCRATCHPAD_SEQ -- requirements
Module: scratchpad_seq

Interface
REQ-001 Parameter ADDR_W, default 10, scratchpad address width; N = 2**ADDR_W entries.
REQ-002 Parameter DATA_W, default 512, width of one scratchpad entry (one salsa X block).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle pulse, begins a ROMix pass; ignored unless state IDLE.
REQ-006 step_valid  input  1  one-cycle pulse, X0/Xaddr from salsa pipeline valid this cycle.
REQ-007 X0  input  DATA_W  current X block from salsa pipeline.
REQ-008 Xaddr  input  ADDR_W  read index j supplied by salsa pipeline.
REQ-009 Bx  output  DATA_W  scratchpad entry V[j] returned to salsa pipeline.
REQ-010 Bx_valid  output  1  one-cycle pulse, Bx valid.
REQ-011 phase  output  2  current FSM state encoding.
REQ-012 busy  output  1  high in WRITE or READ.
REQ-013 done  output  1  one-cycle pulse at end of READ phase.

Function
REQ-014 FSM states SHALL be IDLE=0, WRITE=1, READ=2, DONE=3.
REQ-015 IDLE->WRITE on start; step counter cleared to 0 on the same edge.
REQ-016 In WRITE, each step_valid SHALL write X0 to entry cnt, then cnt increments.
REQ-017 When step_valid arrives with cnt = N-1, write completes, cnt wraps to 0, FSM enters READ next cycle.
REQ-018 In READ, each step_valid SHALL issue a read of entry Xaddr; Xaddr is used modulo N, no range check.
REQ-019 Bx/Bx_valid SHALL appear exactly L cycles after the accepting step_valid (L per REQ-028), one pulse per read, in order.
REQ-020 After the N-th READ step_valid, FSM enters DONE; done pulses one cycle after the last Bx_valid, then FSM returns to IDLE.
REQ-021 Scratchpad SHALL not be written in READ, DONE or IDLE.
REQ-022 step_valid in IDLE or DONE SHALL be ignored (no write, no read, no Bx_valid).
REQ-023 start while busy SHALL be ignored; pass continues unaffected.
REQ-024 Back-to-back step_valid (every cycle) SHALL be supported in both phases without loss.
REQ-025 Read of an address written in the same cycle cannot occur (phases disjoint); no bypass required.

Reset
REQ-026 reset_n low SHALL force state IDLE, cnt 0, Bx 0, Bx_valid 0, busy 0, done 0, phase 0, and flush in-flight read pulses; scratchpad contents undefined.
REQ-027 Reset mid-pass SHALL abort the pass; no done pulse is emitted; next start begins fresh.

Configuration
REQ-028 Macro SCRATCH_RDREG_EN defined: RAM output registered again before Bx, L = 2; undefined: L = 1 (RAM synchronous read only).
REQ-029 In both builds done SHALL follow the final Bx_valid by exactly one cycle.

Structure
REQ-030 Package scrypt_pkg SHALL hold state encodings, default ADDR_W/DATA_W and N.
REQ-031 One sub-module pad_ram: simple dual-port, synchronous write, synchronous registered read, no reset, block-RAM inferrable.
REQ-032 FSM, counter and valid-delay line reside in scratchpad_seq.

Verification
REQ-033 Fill: start, 1024 step_valid with X0 = {16{k}} for k=0..1023 -> phase reaches READ after 1024th pulse, no Bx_valid during WRITE.
REQ-034 Readback: READ steps with Xaddr = 5, 1023, 0 -> Bx = {16{5}}, {16{1023}}, {16{0}}, each exactly L cycles later.
REQ-035 Streaming: 1024 consecutive-cycle READ steps, Xaddr = 1023-i -> 1024 contiguous Bx_valid pulses, correct data, done one cycle after last.
REQ-036 Gaps/ignores: step_valid in IDLE and start during WRITE -> no writes, cnt unchanged, pass unaffected.
REQ-037 Reset at READ step 300 -> all outputs 0 next cycle, no done; new start then runs full pass correctly.
REQ-038 Both builds (SCRATCH_RDREG_EN defined/undefined) run REQ-034 -> L = 2 and L = 1 respectively.
